// File: rtl/pixel_stream_gen.sv
// Pixel-write generator: expands point/rect/clear/checker commands into a raster stream of
// framebuffer writes with valid/ready backpressure. Optional PIXGEN_CLIP_EN clips to the screen.
module pixel_stream_gen #(
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8,
  parameter int unsigned Z_WIDTH     = 8,
  parameter int unsigned RGB_WIDTH   = 12,
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned CHECK_SHIFT = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic [1:0]           mode_in,
  input  logic [X_WIDTH-1:0]   x0_in,
  input  logic [Y_WIDTH-1:0]   y0_in,
  input  logic [X_WIDTH-1:0]   x1_in,
  input  logic [Y_WIDTH-1:0]   y1_in,
  input  logic [Z_WIDTH-1:0]   z_in,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  input  logic [RGB_WIDTH-1:0] rgb_alt_in,
  input  logic                 abort_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [X_WIDTH-1:0]   x_out,
  output logic [Y_WIDTH-1:0]   y_out,
  output logic [Z_WIDTH-1:0]   z_out,
  output logic [RGB_WIDTH-1:0] rgb_out,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModePoint   = 2'd0;
  localparam logic [1:0] ModeClear   = 2'd2;
  localparam logic [1:0] ModeChecker = 2'd3;

  // Counters carry one extra bit so an inclusive end at the coordinate maximum cannot wrap.
  localparam logic [X_WIDTH:0] XMax = (X_WIDTH + 1)'(H_ACTIVE - 1);
  localparam logic [Y_WIDTH:0] YMax = (Y_WIDTH + 1)'(V_ACTIVE - 1);

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [X_WIDTH:0]     x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_WIDTH:0]     y1_q, y1_d, y_q, y_d;
  logic [Z_WIDTH-1:0]   z_q, z_d;
  logic [RGB_WIDTH-1:0] c0_q, c0_d, c1_q, c1_d, rgb_q, rgb_d;
  logic                 valid_q, valid_d, done_q, done_d;
  logic [X_WIDTH:0]     bx0, bx1;
  logic [Y_WIDTH:0]     by0, by1;

  function automatic logic [RGB_WIDTH-1:0] pick_rgb(
    input logic [1:0]           mode,
    input logic [X_WIDTH:0]     x,
    input logic [Y_WIDTH:0]     y,
    input logic [RGB_WIDTH-1:0] c0,
    input logic [RGB_WIDTH-1:0] c1
  );
    if (mode == ModeChecker && (x[CHECK_SHIFT] ^ y[CHECK_SHIFT])) return c1;
    return c0;
  endfunction

  always_comb begin
    bx0 = {1'b0, x0_in};
    by0 = {1'b0, y0_in};
    bx1 = {1'b0, x1_in};
    by1 = {1'b0, y1_in};
    case (mode_in)
      ModeClear: begin
        bx0 = '0;
        by0 = '0;
        bx1 = XMax;
        by1 = YMax;
      end
      ModePoint: begin
        bx1 = bx0;
        by1 = by0;
      end
      default: ;
    endcase
`ifdef PIXGEN_CLIP_EN
    // A start beyond the clipped end yields an empty region.
    if (bx1 > XMax) bx1 = XMax;
    if (by1 > YMax) by1 = YMax;
`endif
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    rgb_d   = rgb_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_in) begin
          mode_d = mode_in;
          x0_d   = bx0;
          x1_d   = bx1;
          y1_d   = by1;
          z_d    = z_in;
          c0_d   = rgb_in;
          c1_d   = rgb_alt_in;
          if (bx1 < bx0 || by1 < by0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
            valid_d = 1'b1;
            x_d     = bx0;
            y_d     = by0;
            rgb_d   = pick_rgb(mode_in, bx0, by0, rgb_in, rgb_alt_in);
          end
        end
      end
      StRun: begin
        if (abort_in) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (ready_in) begin
          if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              state_d = StDone;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_d = x0_q;
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
          rgb_d = pick_rgb(mode_q, x_d, y_d, c0_q, c1_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      mode_q  <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_out = (state_q == StIdle);
  assign busy_out      = (state_q != StIdle);
  assign valid_out     = valid_q;
  assign done_out      = done_q;
  assign x_out         = x_q[X_WIDTH-1:0];
  assign y_out         = y_q[Y_WIDTH-1:0];
  assign z_out         = z_q;
  assign rgb_out       = rgb_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen: raster order, stalls, checker colours, abort, reset, clip.
module tb_pixel_stream_gen;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  mode_in = '0;
  logic [8:0]  x0_in = '0, x1_in = '0, x_out;
  logic [7:0]  y0_in = '0, y1_in = '0, y_out;
  logic [7:0]  z_in = 8'h3C, z_out;
  logic [11:0] rgb_in = '0, rgb_alt_in = '0, rgb_out;
  logic        abort_in = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic        busy_out, done_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  pixel_stream_gen dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out), .mode_in(mode_in), .x0_in(x0_in), .y0_in(y0_in),
    .x1_in(x1_in), .y1_in(y1_in), .z_in(z_in), .rgb_in(rgb_in), .rgb_alt_in(rgb_alt_in),
    .abort_in(abort_in), .valid_out(valid_out), .ready_in(ready_in), .x_out(x_out),
    .y_out(y_out), .z_out(z_out), .rgb_out(rgb_out), .busy_out(busy_out), .done_out(done_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and follow it to completion against a raster model of the bounds.
  task automatic run_cmd(input string name, input logic [1:0] mode, input int x0, input int y0,
                         input int x1, input int y1, input logic [11:0] c0,
                         input logic [11:0] c1, input int rdy_mode, input int ex0,
                         input int ey0, input int ex1, input int ey1, input int exp_count,
                         input int abort_after);
    int ex, ey, xfers;
    logic stalled, finished;
    logic [63:0] pix, held, want;
    logic [11:0] wc;
    @(negedge clk_in);
    check({name, "_cmd_ready"}, cmd_ready_out, 1);
    cmd_valid_in = 1'b1;
    mode_in = mode;
    x0_in = x0[8:0];
    y0_in = y0[7:0];
    x1_in = x1[8:0];
    y1_in = y1[7:0];
    rgb_in = c0;
    rgb_alt_in = c1;
    @(negedge clk_in);
    cmd_valid_in = 1'b0;
    ex = ex0;
    ey = ey0;
    xfers = 0;
    stalled = 1'b0;
    finished = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < exp_count * 3 + 10 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk_in);
      pix = {27'd0, x_out, y_out, z_out, rgb_out};
      if (stalled) check({name, "_hold"}, pix, held);
      if (xfers == exp_count) begin
        check({name, "_done"}, {valid_out, done_out}, 2'b01);
        finished = 1'b1;
      end else begin
        check({name, "_valid_busy"}, {valid_out, busy_out, done_out}, 3'b110);
        ready_in = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        stalled = !ready_in;
        held = pix;
        if (ready_in) begin
          wc = (mode == 2'd3 && (((ex >> 3) ^ (ey >> 3)) & 1) == 1) ? c1 : c0;
          want = {27'd0, ex[8:0], ey[7:0], 8'h3C, wc};
          check({name, "_pixel"}, pix, want);
          if (ex == ex1) begin
            ex = ex0;
            ey++;
          end else begin
            ex++;
          end
          xfers++;
          if (abort_after > 0 && xfers == abort_after) begin
            abort_in = 1'b1;
            @(negedge clk_in);
            abort_in = 1'b0;
            ready_in = 1'b1;
            check({name, "_abort_state"}, {valid_out, done_out, busy_out, cmd_ready_out},
                  4'b0001);
            @(negedge clk_in);
            check({name, "_abort_nodone"}, done_out, 0);
            return;
          end
        end
      end
    end
    if (!finished) check({name, "_timeout"}, 0, 1);
    ready_in = 1'b1;
    @(negedge clk_in);
    check({name, "_after_done"}, {done_out, busy_out, cmd_ready_out, valid_out}, 4'b0010);
  endtask

  initial begin
    logic seen_done;
    #22;
    check("reset_outputs", {valid_out, done_out, busy_out, cmd_ready_out, x_out, y_out, z_out,
                            rgb_out}, {4'b0001, 37'd0});
    @(negedge clk_in);
    rst_n_in = 1'b1;

    run_cmd("point", 2'd0, 5, 7, 0, 0, 12'hFFF, 12'h000, 0, 5, 7, 5, 7, 1, 0);
    run_cmd("rect", 2'd1, 2, 3, 4, 4, 12'h123, 12'h000, 0, 2, 3, 4, 4, 6, 0);
    run_cmd("stall", 2'd1, 0, 0, 3, 0, 12'h0A0, 12'h000, 1, 0, 0, 3, 0, 4, 0);
    run_cmd("checker", 2'd3, 0, 0, 15, 0, 12'hF00, 12'h00F, 0, 0, 0, 15, 0, 16, 0);
    run_cmd("checker2", 2'd3, 4, 7, 11, 8, 12'hF00, 12'h00F, 1, 4, 7, 11, 8, 16, 0);
    run_cmd("clear_abort", 2'd2, 9, 9, 1, 1, 12'h777, 12'h000, 0, 0, 0, 319, 239, 76800, 10);
    run_cmd("point_after_abort", 2'd0, 100, 50, 0, 0, 12'hABC, 12'h000, 0, 100, 50, 100, 50,
            1, 0);
`ifdef PIXGEN_CLIP_EN
    run_cmd("clip_rect", 2'd1, 300, 230, 330, 250, 12'h456, 12'h000, 0, 300, 230, 319, 239,
            200, 0);
    run_cmd("offscreen", 2'd1, 400, 5, 410, 6, 12'h456, 12'h000, 0, 0, 0, 0, 0, 0, 0);
`else
    run_cmd("noclip_rect", 2'd1, 300, 230, 330, 250, 12'h456, 12'h000, 0, 300, 230, 330, 250,
            651, 0);
`endif
    run_cmd("empty", 2'd1, 5, 5, 4, 5, 12'h111, 12'h000, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a rect must leave no trailing completion pulse.
    @(negedge clk_in);
    cmd_valid_in = 1'b1;
    mode_in = 2'd1;
    x0_in = 9'd0;
    y0_in = 8'd0;
    x1_in = 9'd9;
    y1_in = 8'd9;
    @(negedge clk_in);
    cmd_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check("midreset_outputs", {valid_out, busy_out, done_out, cmd_ready_out, x_out, rgb_out},
             {4'b0001, 21'd0});
    @(negedge clk_in);
    rst_n_in = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk_in);
      if (done_out || valid_out) seen_done = 1'b1;
    end
    check("midreset_quiet", seen_done, 0);
    run_cmd("point_after_reset", 2'd0, 1, 2, 0, 0, 12'h5A5, 12'h000, 0, 1, 2, 1, 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
